// File: rtl/playback_timer_ctrl_if.sv
// playback_timer_ctrl_if: Avalon-MM link between the playback sequencer and the interval timer s1 slave.
interface playback_timer_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/playback_timer_ctrl.sv
// playback_timer_ctrl: sequences the 1 s interval timer over Avalon-MM and turns its timeouts
// into an mm:ss playback clock with a per-second tick.
module playback_timer_ctrl #(
    parameter int MAX_MIN   = 99,
    parameter int RETRY_MAX = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_play,
    input  logic                  cmd_pause,
    input  logic                  cmd_stop,
    playback_timer_ctrl_if.master tmr,
    output logic                  playing,
    output logic                  paused,
    output logic [5:0]            elapsed_sec,
    output logic [6:0]            elapsed_min,
    output logic                  tick,
    output logic                  error
);
    typedef enum logic [3:0] {IDLE, CLR, RELOAD, CFG, START, VFY_A, VFY_D, RUN, ACK, PSTOP, PAUSED, ERR, SSTOP} state_t;
    localparam logic [1:0] C_NONE = 2'd0, C_PLAY = 2'd1, C_PAUSE = 2'd2, C_STOP = 2'd3;
    state_t      state_q, state_d;
    logic [1:0]  pend_q, pend_d, cmd_now, cmd_eff;
    logic [7:0]  retry_q, retry_d;
    logic [5:0]  sec_q, sec_d;
    logic [6:0]  min_q, min_d;
    logic        playing_q, playing_d, paused_q, paused_d, error_q, error_d, tick_q, tick_d;
    logic [2:0]  addr_q, addr_d;
    logic        cs_q, cs_d, wn_q, wn_d;
    logic [15:0] wd_q, wd_d;
    logic        at_max, unused_rd;

    // Command codes are ordered by priority, so merging with the pending one is a max().
    assign cmd_now   = cmd_stop ? C_STOP : cmd_pause ? C_PAUSE : cmd_play ? C_PLAY : C_NONE;
    assign cmd_eff   = (cmd_now > pend_q) ? cmd_now : pend_q;
    assign at_max    = (min_q == 7'(MAX_MIN)) && (sec_q == 6'd59);
    assign unused_rd = ^{tmr.readdata[15:2], tmr.readdata[0]};

    always_comb begin
        state_d   = state_q;
        pend_d    = cmd_eff;
        retry_d   = retry_q;
        sec_d     = sec_q;
        min_d     = min_q;
        playing_d = playing_q;
        paused_d  = paused_q;
        error_d   = error_q;
        tick_d    = 1'b0;
        case (state_q)
            IDLE: begin
                pend_d = C_NONE;
                if (cmd_eff == C_PLAY) begin
                    state_d = CLR;
                    sec_d   = '0;
                    min_d   = '0;
                    retry_d = '0;
                end
            end
            CLR:    state_d = RELOAD;
            RELOAD: state_d = CFG;
            CFG:    state_d = START;
            START:  state_d = VFY_A;
            VFY_A:  state_d = VFY_D;
            VFY_D: begin
                if (tmr.readdata[1]) begin
                    state_d   = RUN;
                    playing_d = 1'b1;
                    paused_d  = 1'b0;
                    retry_d   = '0;
                end else begin
                    retry_d = retry_q + 8'd1;
                    state_d = (retry_d == 8'(RETRY_MAX)) ? ERR : START;
                    error_d = (retry_d == 8'(RETRY_MAX));
                end
            end
            RUN: begin
                pend_d = C_NONE;
                if (cmd_eff == C_STOP) state_d = SSTOP;
                else if (tmr.irq) begin
                    // A pause arriving with the timeout waits behind the ACK.
                    state_d = ACK;
                    tick_d  = 1'b1;
                    pend_d  = cmd_eff;
                    sec_d   = at_max ? sec_q : (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                    min_d   = (at_max || sec_q != 6'd59) ? min_q : min_q + 7'd1;
                end else if (cmd_eff == C_PAUSE) state_d = PSTOP;
            end
            ACK: state_d = RUN;
            PSTOP: begin
                state_d   = PAUSED;
                playing_d = 1'b0;
                paused_d  = 1'b1;
            end
            PAUSED: begin
                pend_d  = C_NONE;
                state_d = (cmd_eff == C_STOP) ? SSTOP : (cmd_eff == C_PLAY) ? START : PAUSED;
            end
            ERR: begin
                pend_d  = C_NONE;
                state_d = (cmd_eff == C_STOP) ? SSTOP : ERR;
            end
            SSTOP: begin
                state_d   = IDLE;
                pend_d    = C_NONE;
                retry_d   = '0;
                sec_d     = '0;
                min_d     = '0;
                playing_d = 1'b0;
                paused_d  = 1'b0;
                error_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus cycle is a function of the state being entered, so it appears registered alongside it.
    always_comb begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = 3'd0;
        wd_d   = 16'h0000;
        case (state_d)
            CLR, ACK: addr_d = 3'd0;
            RELOAD:   addr_d = 3'd2;
            CFG:      begin addr_d = 3'd1; wd_d = 16'h0003; end
            START:    begin addr_d = 3'd1; wd_d = 16'h0007; end
            VFY_A:    wn_d = 1'b1;
            PSTOP:    begin addr_d = 3'd1; wd_d = 16'h000B; end
            SSTOP:    begin addr_d = 3'd1; wd_d = 16'h0008; end
            ERR: begin
                if (state_q == ERR) begin
                    cs_d = 1'b0;
                    wn_d = 1'b1;
                end else begin
                    addr_d = 3'd1;
                    wd_d   = 16'h0008;
                end
            end
            default: begin cs_d = 1'b0; wn_d = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pend_q    <= C_NONE;
            retry_q   <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            playing_q <= 1'b0;
            paused_q  <= 1'b0;
            error_q   <= 1'b0;
            tick_q    <= 1'b0;
            addr_q    <= '0;
            cs_q      <= 1'b0;
            wn_q      <= 1'b1;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            retry_q   <= retry_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            playing_q <= playing_d;
            paused_q  <= paused_d;
            error_q   <= error_d;
            tick_q    <= tick_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            wn_q      <= wn_d;
            wd_q      <= wd_d;
        end
    end

    assign tmr.address    = addr_q;
    assign tmr.chipselect = cs_q;
    assign tmr.write_n    = wn_q;
    assign tmr.writedata  = wd_q;
    assign playing        = playing_q;
    assign paused         = paused_q;
    assign elapsed_sec    = sec_q;
    assign elapsed_min    = min_q;
    assign tick           = tick_q;
    assign error          = error_q;
endmodule

// File: tb/tb_playback_timer_ctrl.sv
// tb_playback_timer_ctrl: drives playback_timer_ctrl against a 20-cycle interval timer model and
// checks bus traces, ticks and the mm:ss clock derived from the model's own timeout count.
module tb_playback_timer_ctrl;
    localparam int MAX_MIN = 2;
    localparam int MAXT    = MAX_MIN * 60 + 59;

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_play = 1'b0, cmd_pause = 1'b0, cmd_stop = 1'b0;
    logic playing, paused, tick, error;
    logic [5:0] elapsed_sec;
    logic [6:0] elapsed_min;

    playback_timer_ctrl_if tif();

    playback_timer_ctrl #(.MAX_MIN(MAX_MIN), .RETRY_MAX(3)) dut (
        .clk(clk), .reset(rst), .cmd_play(cmd_play), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop),
        .tmr(tif.master), .playing(playing), .paused(paused), .elapsed_sec(elapsed_sec),
        .elapsed_min(elapsed_min), .tick(tick), .error(error)
    );

    always #5 clk = ~clk;

    // Interval timer model: period 20 cycles, continuous, START optionally ignored.
    logic tm_to = 1'b0, tm_run = 1'b0, tm_ito = 1'b0, ignore_start = 1'b0;
    logic [15:0] rdata = 16'h0;
    int tm_cnt = 0, to_cnt = 0;
    wire bus_wr = tif.chipselect && !tif.write_n;
    always @(posedge clk) begin
        if (bus_wr && tif.address == 3'd0) tm_to <= 1'b0;
        if (tm_run && tm_cnt == 19) begin
            tm_cnt <= 0;
            tm_to  <= 1'b1;
            to_cnt <= to_cnt + 1;
        end else if (tm_run) tm_cnt <= tm_cnt + 1;
        if (bus_wr && tif.address == 3'd2) tm_cnt <= 0;
        if (bus_wr && tif.address == 3'd1) begin
            tm_ito <= tif.writedata[0];
            if (tif.writedata[3]) tm_run <= 1'b0;
            else if (tif.writedata[2] && !ignore_start) tm_run <= 1'b1;
        end
        rdata <= (tif.chipselect && tif.write_n && tif.address == 3'd0) ? {14'd0, tm_run, tm_to} : 16'h0;
    end
    assign tif.readdata = rdata;
    assign tif.irq      = tm_to & tm_ito;

    // Bus monitor
    typedef struct {int cyc; logic wr; logic [2:0] a; logic [15:0] d;} bus_t;
    bus_t tr[$];
    int cyc = 0, tick_cnt = 0, play_rise = -1;
    logic play_prev = 1'b0;
    always @(posedge clk) begin
        if (tif.chipselect) tr.push_back('{cyc, !tif.write_n, tif.address, tif.writedata});
        if (tick) tick_cnt <= tick_cnt + 1;
        play_prev <= playing;
        if (playing && !play_prev) play_rise <= cyc;
        cyc <= cyc + 1;
    end

    int n_cmp = 0, n_bad = 0;
    int base = 0, tk, n0, cp, w, rd, mode;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_t();
        int t = to_cnt - base;
        return (t > MAXT) ? MAXT : t;
    endfunction

    task automatic chk_time(input string tag);
        chk({tag, "_sec"}, int'(elapsed_sec), exp_t() % 60);
        chk({tag, "_min"}, int'(elapsed_min), exp_t() / 60);
    endtask

    task automatic chk_bus(input string tag, input int i, input int wr, input int a, input int d);
        chk({tag, "_wr"}, (i < tr.size()) ? int'(tr[i].wr) : -1, wr);
        chk({tag, "_addr"}, (i < tr.size()) ? int'(tr[i].a) : -1, a);
        chk({tag, "_data"}, (i < tr.size()) ? int'(tr[i].d) : -1, d);
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int c);
        cmd_play  = (c == 1);
        cmd_pause = (c == 2);
        cmd_stop  = (c == 3);
        @(negedge clk);
        cmd_play  = 1'b0;
        cmd_pause = 1'b0;
        cmd_stop  = 1'b0;
    endtask

    task automatic wait_to(input int target);
        int lim = 0;
        while (to_cnt < target && lim < 5000) begin @(negedge clk); lim++; end
        chk("wait_timeout_bound", int'(to_cnt >= target), 1);
    endtask

    task automatic wait_irq();
        int lim = 0;
        while (!tif.irq && lim < 100) begin @(negedge clk); lim++; end
        chk("wait_irq_bound", int'(tif.irq), 1);
    endtask

    initial begin
        cyc_n(3);
        chk("rst_playing", playing, 0);
        chk("rst_paused", paused, 0);
        chk("rst_error", error, 0);
        chk("rst_tick", tick, 0);
        chk("rst_sec", elapsed_sec, 0);
        chk("rst_min", elapsed_min, 0);
        chk("rst_cs", tif.chipselect, 0);
        chk("rst_write_n", tif.write_n, 1);
        chk("rst_addr", tif.address, 0);
        chk("rst_wdata", tif.writedata, 0);
        rst = 1'b0;
        cyc_n(2);
        // Start sequence trace
        tr.delete();
        base = to_cnt;
        pulse(1);
        cyc_n(10);
        chk("start_trace_len", tr.size(), 5);
        chk_bus("start_clr", 0, 1, 0, 0);
        chk_bus("start_reload", 1, 1, 2, 0);
        chk_bus("start_cfg", 2, 1, 1, 3);
        chk_bus("start_start", 3, 1, 1, 7);
        chk_bus("start_read", 4, 0, 0, 0);
        for (int i = 1; i < 5 && i < tr.size(); i++) chk("start_consecutive", tr[i].cyc - tr[0].cyc, i);
        chk("playing_latency", (tr.size() >= 5) ? play_rise - tr[4].cyc : -1, 2);
        chk("playing_on", playing, 1);
        // Pause at 00:05, hold, resume
        wait_to(base + 5);
        cyc_n(4);
        chk_time("at5");
        cyc_n($urandom_range(2, 10));
        n0 = tr.size();
        pulse(2);
        cyc_n(4);
        chk_bus("pause_wr", n0, 1, 1, 16'h000B);
        chk("pause_paused", paused, 1);
        chk("pause_playing", playing, 0);
        tk = tick_cnt;
        cp = tm_cnt;
        cyc_n(100);
        chk("pause_no_tick", tick_cnt - tk, 0);
        chk_time("pause_hold");
        n0 = tr.size();
        pulse(1);
        w = 0;
        while (tick_cnt == tk && w < 60) begin @(negedge clk); w++; end
        chk("resume_first_tick_in_time", int'(w <= 24 - cp), 1);
        chk_bus("resume_start", n0, 1, 1, 7);
        cyc_n(3);
        chk_time("resume");
        chk("resume_playing", playing, 1);
        chk("resume_paused", paused, 0);
        // Timeout coinciding with pause
        wait_irq();
        tk = tick_cnt;
        n0 = tr.size();
        pulse(2);
        cyc_n(6);
        chk("irqpause_tick", tick_cnt - tk, 1);
        chk_time("irqpause");
        chk("irqpause_trace_len", tr.size() - n0, 2);
        chk_bus("irqpause_ack", n0, 1, 0, 0);
        chk_bus("irqpause_pstop", n0 + 1, 1, 1, 16'h000B);
        chk("irqpause_paused", paused, 1);
        pulse(1);
        cyc_n(8);
        chk("irqpause_resume", playing, 1);
        // Timeout coinciding with stop
        wait_irq();
        tk = tick_cnt;
        n0 = tr.size();
        pulse(3);
        cyc_n(6);
        chk("irqstop_tick", tick_cnt - tk, 0);
        chk("irqstop_trace_len", tr.size() - n0, 1);
        chk_bus("irqstop_sstop", n0, 1, 1, 8);
        chk("irqstop_sec", elapsed_sec, 0);
        chk("irqstop_min", elapsed_min, 0);
        chk("irqstop_playing", playing, 0);
        // 61 periods, then saturation
        base = to_cnt;
        tk = tick_cnt;
        n0 = tr.size();
        pulse(1);
        wait_to(base + 61);
        cyc_n(4);
        chk("run61_ticks", tick_cnt - tk, 61);
        rd = 0;
        for (int i = n0; i < tr.size(); i++) if (tr[i].wr && tr[i].a == 3'd0) rd++;
        chk("run61_wr0", rd, 62);
        chk_time("run61");
        wait_to(base + MAX_MIN * 60 + 58);
        cyc_n(4);
        chk_time("pre_sat");
        tk = tick_cnt;
        wait_to(base + MAX_MIN * 60 + 61);
        cyc_n(4);
        chk("sat_ticks", tick_cnt - tk, 3);
        chk("sat_sec", elapsed_sec, 59);
        chk("sat_min", elapsed_min, MAX_MIN);
        pulse(3);
        cyc_n(4);
        // Timer refuses to start
        ignore_start = 1'b1;
        n0 = tr.size();
        pulse(1);
        cyc_n(30);
        rd = 0;
        for (int i = n0; i < tr.size(); i++) if (!tr[i].wr) rd++;
        chk("err_reads", rd, 3);
        chk_bus("err_stopwr", tr.size() - 1, 1, 1, 8);
        chk("err_flag", error, 1);
        chk("err_playing", playing, 0);
        chk("err_sec_zeroed", elapsed_sec, 0);
        pulse(3);
        cyc_n(5);
        chk("err_cleared", error, 0);
        chk_bus("err_sstop", tr.size() - 1, 1, 1, 8);
        chk("err_bus_idle", tif.chipselect, 0);
        ignore_start = 1'b0;
        // Random command sequence against an abstract player mode
        mode = 0;
        for (int k = 0; k < 10; k++) begin
            int c = $urandom_range(1, 3);
            pulse(c);
            mode = (c == 3) ? 0 : (c == 2) ? ((mode == 1) ? 2 : mode) : 1;
            cyc_n($urandom_range(30, 60));
            chk("rand_playing", playing, int'(mode == 1));
            chk("rand_paused", paused, int'(mode == 2));
            if (mode == 0) chk("rand_stopped_sec", elapsed_sec, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
